// File: rtl/lsu.sv
// Load/store unit for the R4 memory stage: one ready-handshaked data-memory
// transaction per accepted request, returning extended load data and fault flags.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        access_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misaligned_q, misaligned_d;
    logic        access_fault_q, access_fault_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic [7:0]  cnt_inc;

    // Request decode on the live inputs; only meaningful while IDLE.
    always_comb begin
        if (is_store) begin
            req_illegal = (funct3 >= 3'b011);
        end else begin
            req_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  rd_ext = mem_rdata;
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = 32'd0;
        endcase
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        is_store_d     = is_store_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
        cnt_d          = cnt_q;
        load_data_d    = load_data_q;
        misaligned_d   = misaligned_q;
        access_fault_d = access_fault_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_store_d     = is_store;
                    funct3_d       = funct3;
                    addr_lo_d      = addr[1:0];
                    load_data_d    = 32'd0;
                    misaligned_d   = 1'b0;
                    access_fault_d = 1'b0;
                    if (req_illegal) begin
                        access_fault_d = 1'b1;
                        state_d        = DONE;
                    end else if (req_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d    = ACCESS;
                        cnt_d      = 8'd0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = is_store;
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (!is_store) begin
                            mem_wstrb_d = 4'b0000;
                            mem_wdata_d = 32'd0;
                        end else begin
                            case (funct3[1:0])
                                2'b00: begin
                                    mem_wstrb_d = 4'b0001 << addr[1:0];
                                    mem_wdata_d = {4{store_data[7:0]}};
                                end
                                2'b01: begin
                                    mem_wstrb_d = 4'b0011 << addr[1:0];
                                    mem_wdata_d = {2{store_data[15:0]}};
                                end
                                default: begin
                                    mem_wstrb_d = 4'b1111;
                                    mem_wdata_d = store_data;
                                end
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    if (!is_store_q) begin
                        load_data_d = rd_ext;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(TIMEOUT)) begin
                        state_d        = DONE;
                        access_fault_d = 1'b1;
                        mem_req_d      = 1'b0;
                        mem_we_d       = 1'b0;
                        mem_wstrb_d    = 4'b0000;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            is_store_q     <= 1'b0;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 2'd0;
            cnt_q          <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            load_data_q    <= 32'd0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            mem_wstrb_q    <= 4'd0;
        end else begin
            // NOTE: non-blocking updates make every flop see pre-edge values,
            // so the register order inside this block does not matter.
            state_q        <= state_d;
            is_store_q     <= is_store_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            load_data_q    <= load_data_d;
            misaligned_q   <= misaligned_d;
            access_fault_q <= access_fault_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign load_data    = load_data_q;
    assign misaligned   = misaligned_q;
    assign access_fault = access_fault_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;

endmodule
